driver_frame_scheduler: RTL and testbench
=========================================

Name: driver_frame_scheduler

Overview:
Sequences the LED driver controller: converts rotation position ticks into SOF pulses and tracks slice/column progress via EOC. Serialises host configuration writes (start_config/config_data) into gaps between frames so SOF and config never collide. Sits between the rotation sensing / SPI host logic and the driver controller; its slice_idx output selects the framebuffer slice feeding the data bus.

Parameters:
SLICES, 256, slices per revolution; slice_idx wraps at SLICES-1
COLUMNS_PER_SOF, 8, EOC pulses that complete one SOF-started frame
CONFIG_TIMEOUT, 4096, clk_enable cycles allowed between start_config and end_config
IDX_W, 8, width of slice_idx, must satisfy 2**IDX_W >= SLICES

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
clk_enable  in  1  driver clock-enable strobe, same signal the driver controller uses
rot_tick  in  1  one-clk pulse per slice position
rot_index  in  1  one-clk pulse at the mechanical zero position, may coincide with rot_tick
cfg_valid  in  1  host config request
cfg_data  in  48  host config word
cfg_ready  out  1  config word accepted this cycle
sof  out  1  to driver controller SOF
start_config  out  1  to driver controller start_config, one clk pulse
config_data  out  48  to driver controller config_data
eoc  in  1  from driver controller EOC
end_config  in  1  from driver controller end_config
slice_idx  out  IDX_W  slice currently displayed
overrun_cnt  out  16  dropped rot_ticks, saturating
cfg_timeout  out  1  sticky; set on config timeout

Behaviour:
- Reset values: sof=0, start_config=0, config_data=0, cfg_ready=0, slice_idx=0, overrun_cnt=0, cfg_timeout=0, state=BOOT_WAIT, tick_pend=0, cfg_pend=0.
- Input capture every clk, independent of clk_enable: rot_tick sets tick_pend; rot_index sets index_pend. cfg_ready=1 for one clk when cfg_valid && !cfg_pend; cfg_data is then latched into config_data and cfg_pend is set.
- FSM, advances only on clk_enable cycles unless noted:
  - BOOT_WAIT: the driver self-configures after reset. Go to READY on end_config. Ticks arriving in this state are discarded and not counted.
  - READY:
    - If tick_pend: assert sof, clear tick_pend, go to FRAME, eoc_cnt=0.
    - If index_pend is also set: slice_idx=0 and clear index_pend. Otherwise slice_idx increments, wrapping SLICES-1 -> 0.
    - Else if cfg_pend: pulse start_config for exactly one clk, clear cfg_pend, load timeout counter, go to CONFIG.
    - tick has priority over config. sof and start_config are never asserted in the same cycle.
  - FRAME:
    - sof is held high until the first clk_enable cycle after entry, then driven 0.
    - Each eoc increments eoc_cnt. At eoc_cnt==COLUMNS_PER_SOF-1 with eoc, go to READY.
    - A tick_pend already set when a new rot_tick arrives: overrun_cnt+1, saturating at 0xFFFF.
  - CONFIG: end_config -> READY. Timeout counter reaching 0 -> set cfg_timeout, go to READY.
- tick_pend is single-depth; a pending tick is served on the first READY cycle, latency 1 clk_enable cycle.
- sof is registered; latency from rot_tick in READY to sof = 1 clk after the next clk_enable.
- rot_index without rot_tick only arms index_pend; it takes effect at the next served tick.
- Simultaneous cfg_valid and end_config: both are handled. Acceptance does not depend on the FSM state.
- Mid-operation nrst returns all state to reset values. The driver controller is reset on the same nrst and re-runs its boot config, so BOOT_WAIT is the correct resume point.

Decomposition:
- Shared package driver_pkg: scheduler state enum (BOOT_WAIT, READY, FRAME, CONFIG), config word width constant (48), default COLUMNS_PER_SOF.
- One sub-module, tick_capture: the sticky pending-flag register with overrun detection, instantiated for rot_tick. rot_index reuses it with the overrun output unused.

Test Plan:
- Reset, end_config pulse, then rot_tick -> sof high within 2 clk_enable cycles; slice_idx 0->1; after 8 eoc pulses the FSM returns to READY.
- Two rot_ticks during FRAME, before 8 eoc -> overrun_cnt=1; exactly one further sof after the 8th eoc; slice_idx increments by 2 in total.
- cfg_valid with cfg_data=48'h0123_4567_89AB during FRAME -> cfg_ready pulse, config_data=48'h0123_4567_89AB; start_config pulses only after the frame ends; never coincident with sof.
- rot_tick and pending config both present in READY -> sof first; start_config follows after the next frame completes.
- rot_index with rot_tick at slice_idx=200 -> slice_idx=0. Also 256 ticks without index -> slice_idx wraps 255->0.
- start_config with no end_config for 4096 clk_enable cycles -> cfg_timeout=1; FSM back in READY; next rot_tick produces sof.

Source files
------------

// File: rtl/driver_pkg.sv
// Shared scheduler types and constants for the LED driver frame scheduler.
package driver_pkg;

    typedef enum logic [1:0] {
        BOOT_WAIT = 2'd0,
        READY     = 2'd1,
        FRAME     = 2'd2,
        CONFIG    = 2'd3
    } sched_state_t;

    localparam int CFG_W                   = 48;
    localparam int DEFAULT_COLUMNS_PER_SOF = 8;
    localparam int OVR_W                   = 16;

    // Saturating increment for the dropped-tick counter.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        if (v == {OVR_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + OVR_W'(1);
        end
    endfunction

endpackage

// File: rtl/driver_frame_scheduler_if.sv
// Host config handshake and driver-controller control bus of the frame scheduler.
interface driver_frame_scheduler_if;
    import driver_pkg::*;

    logic             cfg_valid;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             sof;
    logic             start_config;
    logic [CFG_W-1:0] config_data;
    logic             eoc;
    logic             end_config;

    modport master (
        input  cfg_valid, cfg_data, eoc, end_config,
        output cfg_ready, sof, start_config, config_data
    );

    modport slave (
        output cfg_valid, cfg_data, eoc, end_config,
        input  cfg_ready, sof, start_config, config_data
    );

endinterface

// File: rtl/tick_capture.sv
// Single-depth sticky pending flag; flags a new event that lands on an
// already pending one.
module tick_capture (
    input  logic clk,
    input  logic nrst,
    input  logic set,
    input  logic clear,
    output logic pend,
    output logic overrun
);

    logic pend_r;
    logic overrun_r;

    // Pending flag; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            pend_r    <= set | (pend_r & ~clear);
            overrun_r <= set & pend_r & ~clear;
        end
    end

    assign pend    = pend_r;
    assign overrun = overrun_r;

endmodule

// File: rtl/driver_frame_scheduler.sv
// Turns rotation ticks into SOF frames for the LED driver controller and slots
// host config writes into the gaps between frames.
module driver_frame_scheduler
    import driver_pkg::*;
#(
    parameter int SLICES          = 256,
    parameter int COLUMNS_PER_SOF = DEFAULT_COLUMNS_PER_SOF,
    parameter int CONFIG_TIMEOUT  = 4096,
    parameter int IDX_W           = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clk_enable,
    input  logic                     rot_tick,
    input  logic                     rot_index,
    driver_frame_scheduler_if.master bus,
    output logic [IDX_W-1:0]         slice_idx,
    output logic [OVR_W-1:0]         overrun_cnt,
    output logic                     cfg_timeout
);

    localparam int EOC_W = (COLUMNS_PER_SOF > 1) ? $clog2(COLUMNS_PER_SOF) : 1;
    localparam int TMR_W = $clog2(CONFIG_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_SLICE = IDX_W'(SLICES - 1);
    localparam logic [EOC_W-1:0] LAST_COL   = EOC_W'(COLUMNS_PER_SOF - 1);

    sched_state_t     state_r, state_s;
    logic             sof_r, sof_s;
    logic             start_config_r, start_config_s;
    logic [IDX_W-1:0] slice_idx_r, slice_idx_s;
    logic [EOC_W-1:0] eoc_cnt_r, eoc_cnt_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic             cfg_timeout_r, cfg_timeout_s;
    logic [OVR_W-1:0] overrun_cnt_r, overrun_cnt_s;
    logic             cfg_ready_r;
    logic             cfg_pend_r;
    logic [CFG_W-1:0] config_data_r;

    logic tick_set_s;
    logic tick_pend_s;
    logic tick_ovr_s;
    logic tick_clear_s;
    logic index_pend_s;
    logic index_ovr_unused_s;
    logic index_clear_s;
    logic cfg_clear_s;

    // Ticks during driver boot are discarded rather than queued.
    assign tick_set_s = rot_tick & (state_r != BOOT_WAIT);

    tick_capture u_tick_capture (
        .clk     (clk),
        .nrst    (nrst),
        .set     (tick_set_s),
        .clear   (tick_clear_s),
        .pend    (tick_pend_s),
        .overrun (tick_ovr_s)
    );

    tick_capture u_index_capture (
        .clk     (clk),
        .nrst    (nrst),
        .set     (rot_index),
        .clear   (index_clear_s),
        .pend    (index_pend_s),
        .overrun (index_ovr_unused_s)
    );

    // Host config acceptance runs every clk, independent of scheduler state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_ready_r   <= 1'b0;
            cfg_pend_r    <= 1'b0;
            config_data_r <= {CFG_W{1'b0}};
        end else begin
            cfg_ready_r <= bus.cfg_valid & ~cfg_pend_r;
            if (bus.cfg_valid && !cfg_pend_r) begin
                cfg_pend_r    <= 1'b1;
                config_data_r <= bus.cfg_data;
            end else if (cfg_clear_s) begin
                cfg_pend_r <= 1'b0;
            end else begin
                cfg_pend_r <= cfg_pend_r;
            end
        end
    end

    // Scheduler next-state and registered-output logic.
    always_comb begin
        state_s        = state_r;
        sof_s          = sof_r;
        start_config_s = 1'b0;
        slice_idx_s    = slice_idx_r;
        eoc_cnt_s      = eoc_cnt_r;
        timer_s        = timer_r;
        cfg_timeout_s  = cfg_timeout_r;
        tick_clear_s   = 1'b0;
        index_clear_s  = 1'b0;
        cfg_clear_s    = 1'b0;
        overrun_cnt_s  = tick_ovr_s ? sat_inc(overrun_cnt_r) : overrun_cnt_r;
        if (clk_enable) begin
            case (state_r)
                BOOT_WAIT: begin
                    if (bus.end_config) begin
                        state_s = READY;
                    end else begin
                        state_s = BOOT_WAIT;
                    end
                end
                READY: begin
                    // A pending tick always beats a pending config write.
                    if (tick_pend_s) begin
                        sof_s        = 1'b1;
                        tick_clear_s = 1'b1;
                        eoc_cnt_s    = {EOC_W{1'b0}};
                        state_s      = FRAME;
                        if (index_pend_s) begin
                            slice_idx_s   = {IDX_W{1'b0}};
                            index_clear_s = 1'b1;
                        end else if (slice_idx_r == LAST_SLICE) begin
                            slice_idx_s = {IDX_W{1'b0}};
                        end else begin
                            slice_idx_s = slice_idx_r + IDX_W'(1);
                        end
                    end else if (cfg_pend_r) begin
                        start_config_s = 1'b1;
                        cfg_clear_s    = 1'b1;
                        timer_s        = TMR_W'(CONFIG_TIMEOUT);
                        state_s        = CONFIG;
                    end else begin
                        state_s = READY;
                    end
                end
                FRAME: begin
                    sof_s = 1'b0;
                    if (bus.eoc) begin
                        if (eoc_cnt_r == LAST_COL) begin
                            state_s = READY;
                        end else begin
                            eoc_cnt_s = eoc_cnt_r + EOC_W'(1);
                        end
                    end else begin
                        eoc_cnt_s = eoc_cnt_r;
                    end
                end
                CONFIG: begin
                    if (bus.end_config) begin
                        state_s = READY;
                    end else if (timer_r <= TMR_W'(1)) begin
                        cfg_timeout_s = 1'b1;
                        state_s       = READY;
                    end else begin
                        timer_s = timer_r - TMR_W'(1);
                    end
                end
                default: begin
                    state_s = BOOT_WAIT;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Scheduler state and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r        <= BOOT_WAIT;
            sof_r          <= 1'b0;
            start_config_r <= 1'b0;
            slice_idx_r    <= {IDX_W{1'b0}};
            eoc_cnt_r      <= {EOC_W{1'b0}};
            timer_r        <= {TMR_W{1'b0}};
            cfg_timeout_r  <= 1'b0;
            overrun_cnt_r  <= {OVR_W{1'b0}};
        end else begin
            state_r        <= state_s;
            sof_r          <= sof_s;
            start_config_r <= start_config_s;
            slice_idx_r    <= slice_idx_s;
            eoc_cnt_r      <= eoc_cnt_s;
            timer_r        <= timer_s;
            cfg_timeout_r  <= cfg_timeout_s;
            overrun_cnt_r  <= overrun_cnt_s;
        end
    end

    assign bus.cfg_ready    = cfg_ready_r;
    assign bus.sof          = sof_r;
    assign bus.start_config = start_config_r;
    assign bus.config_data  = config_data_r;
    assign slice_idx        = slice_idx_r;
    assign overrun_cnt      = overrun_cnt_r;
    assign cfg_timeout      = cfg_timeout_r;

endmodule

// File: tb/tb_driver_frame_scheduler.sv
// Scoreboard bench for driver_frame_scheduler: stimulus pushes expected
// SOF / config-accept / start_config events, a monitor pops and compares.
module tb_driver_frame_scheduler;
    import driver_pkg::*;

    localparam int EV_SOF   = 0;
    localparam int EV_ACK   = 1;
    localparam int EV_START = 2;

    typedef struct {
        int               kind;
        logic [CFG_W-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             nrst;
    logic             ce_r;
    logic             clk_enable;
    logic             rot_tick;
    logic             rot_index;
    logic [7:0]       slice_idx;
    logic [OVR_W-1:0] overrun_cnt;
    logic             cfg_timeout;
    logic [7:0]       model_slice;

    int   checks      = 0;
    int   failures    = 0;
    int   events_seen = 0;
    int   events_exp  = 0;
    exp_t exp_q[$];

    driver_frame_scheduler_if bus ();

    driver_frame_scheduler dut (
        .clk         (clk),
        .nrst        (nrst),
        .clk_enable  (clk_enable),
        .rot_tick    (rot_tick),
        .rot_index   (rot_index),
        .bus         (bus),
        .slice_idx   (slice_idx),
        .overrun_cnt (overrun_cnt),
        .cfg_timeout (cfg_timeout)
    );

    always #5 clk = ~clk;

    // clk_enable active on every second clk
    always @(posedge clk or negedge nrst) begin
        if (!nrst) ce_r <= 1'b0;
        else       ce_r <= ~ce_r;
    end
    assign clk_enable = ce_r;

    function automatic logic [7:0] next_slice(input logic [7:0] s);
        if (s == 8'd255) return 8'd0;
        else             return s + 8'd1;
    endfunction

    task automatic check_val(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [CFG_W-1:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
        events_exp++;
    endtask

    task automatic got_ev(input int kind, input logic [CFG_W-1:0] data);
        exp_t e;
        events_seen++;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data) begin
                failures++;
                $display("FAIL event: got kind %0d data %0h, expected kind %0d data %0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every DUT event is compared against the head of the queue.
    initial begin : monitor
        logic sof_q;
        sof_q = 1'b0;
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (bus.cfg_ready) got_ev(EV_ACK, bus.config_data);
                if (bus.sof && !sof_q) got_ev(EV_SOF, CFG_W'(slice_idx));
                if (bus.start_config) begin
                    got_ev(EV_START, bus.config_data);
                    check_val("start_with_sof", CFG_W'(bus.sof), {CFG_W{1'b0}});
                end
            end
            sof_q = bus.sof;
        end
    end

    task automatic wait_events(input string name, input int budget);
        int n;
        n = 0;
        while (events_seen < events_exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (events_seen < events_exp) begin
            failures++;
            $display("FAIL %s: %0d events seen, %0d required within %0d clk", name, events_seen, events_exp, budget);
        end
    endtask

    task automatic tick(input logic idx);
        @(negedge clk);
        rot_tick  = 1'b1;
        rot_index = idx;
        @(negedge clk);
        rot_tick  = 1'b0;
        rot_index = 1'b0;
    endtask

    task automatic eoc_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!clk_enable) @(negedge clk);
            bus.eoc = 1'b1;
            @(negedge clk);
            bus.eoc = 1'b0;
        end
    endtask

    task automatic end_cfg_pulse();
        @(negedge clk);
        while (!clk_enable) @(negedge clk);
        bus.end_config = 1'b1;
        @(negedge clk);
        bus.end_config = 1'b0;
    endtask

    task automatic cfg_send(input logic [CFG_W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cfg_ready && n < 8);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic run_frame(input logic idx, input logic [7:0] exp_slice);
        expect_ev(EV_SOF, CFG_W'(exp_slice));
        tick(idx);
        wait_events("frame_sof", 8);
        eoc_pulses(8);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_sof"}, CFG_W'(bus.sof), {CFG_W{1'b0}});
        check_val({tag, "_start_config"}, CFG_W'(bus.start_config), {CFG_W{1'b0}});
        check_val({tag, "_config_data"}, bus.config_data, {CFG_W{1'b0}});
        check_val({tag, "_cfg_ready"}, CFG_W'(bus.cfg_ready), {CFG_W{1'b0}});
        check_val({tag, "_slice_idx"}, CFG_W'(slice_idx), {CFG_W{1'b0}});
        check_val({tag, "_overrun_cnt"}, CFG_W'(overrun_cnt), {CFG_W{1'b0}});
        check_val({tag, "_cfg_timeout"}, CFG_W'(cfg_timeout), {CFG_W{1'b0}});
    endtask

    initial begin
        nrst           = 1'b0;
        rot_tick       = 1'b0;
        rot_index      = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_data   = {CFG_W{1'b0}};
        bus.eoc        = 1'b0;
        bus.end_config = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        nrst = 1'b1;

        // ticks during boot are dropped and not counted
        tick(1'b0);
        repeat (6) @(negedge clk);
        check_val("boot_overrun", CFG_W'(overrun_cnt), {CFG_W{1'b0}});
        check_val("boot_no_sof", CFG_W'(events_seen), {CFG_W{1'b0}});
        end_cfg_pulse();

        // first frame: sof within 2 clk_enable cycles, slice 0 -> 1
        expect_ev(EV_SOF, 48'd1);
        tick(1'b0);
        wait_events("first_sof_latency", 4);
        eoc_pulses(8);

        // two ticks during a frame: one overrun, one deferred sof
        expect_ev(EV_SOF, 48'd2);
        tick(1'b0);
        wait_events("t2_sof_latency", 4);
        tick(1'b0);
        tick(1'b0);
        eoc_pulses(7);
        repeat (6) @(negedge clk);
        check_val("t2_no_early_sof", CFG_W'(events_seen), CFG_W'(events_exp));
        check_val("t2_overrun", CFG_W'(overrun_cnt), 48'd1);
        expect_ev(EV_SOF, 48'd3);
        eoc_pulses(1);
        wait_events("t2_deferred_sof", 8);
        eoc_pulses(8);

        // config accepted during a frame, started only after it ends
        expect_ev(EV_SOF, 48'd4);
        tick(1'b0);
        wait_events("t3_sof", 4);
        expect_ev(EV_ACK, 48'h0123_4567_89AB);
        cfg_send(48'h0123_4567_89AB);
        wait_events("t3_ack", 4);
        eoc_pulses(7);
        repeat (6) @(negedge clk);
        check_val("t3_no_early_start", CFG_W'(events_seen), CFG_W'(events_exp));
        expect_ev(EV_START, 48'h0123_4567_89AB);
        eoc_pulses(1);
        wait_events("t3_start", 8);
        end_cfg_pulse();

        // tick and config both pending in READY: sof first
        expect_ev(EV_SOF, 48'd5);
        tick(1'b0);
        wait_events("t4_sof", 4);
        expect_ev(EV_ACK, 48'hA5A5_0000_FFFF);
        cfg_send(48'hA5A5_0000_FFFF);
        wait_events("t4_ack", 4);
        tick(1'b0);
        eoc_pulses(8);
        expect_ev(EV_SOF, 48'd6);
        wait_events("t4_sof_before_cfg", 8);
        eoc_pulses(7);
        repeat (6) @(negedge clk);
        check_val("t4_no_early_start", CFG_W'(events_seen), CFG_W'(events_exp));
        expect_ev(EV_START, 48'hA5A5_0000_FFFF);
        eoc_pulses(1);
        wait_events("t4_start", 8);
        end_cfg_pulse();

        // index handling and wrap
        model_slice = 8'd6;
        while (model_slice != 8'd200) begin
            model_slice = next_slice(model_slice);
            run_frame(1'b0, model_slice);
        end
        check_val("slice_at_200", CFG_W'(slice_idx), 48'd200);
        run_frame(1'b1, 8'd0);
        run_frame(1'b0, 8'd1);
        run_frame(1'b0, 8'd2);
        @(negedge clk);
        rot_index = 1'b1;
        @(negedge clk);
        rot_index = 1'b0;
        repeat (4) @(negedge clk);
        check_val("index_alone_holds", CFG_W'(slice_idx), 48'd2);
        run_frame(1'b0, 8'd0);
        model_slice = 8'd0;
        for (int i = 0; i < 256; i++) begin
            model_slice = next_slice(model_slice);
            run_frame(1'b0, model_slice);
        end
        check_val("wrap_slice", CFG_W'(slice_idx), 48'd0);

        // config timeout after 4096 clk_enable cycles
        expect_ev(EV_ACK, 48'h0000_DEAD_BEEF);
        expect_ev(EV_START, 48'h0000_DEAD_BEEF);
        cfg_send(48'h0000_DEAD_BEEF);
        wait_events("t6_start", 12);
        repeat (2 * 4090) @(negedge clk);
        check_val("timeout_not_early", CFG_W'(cfg_timeout), 48'd0);
        repeat (2 * 20) @(negedge clk);
        check_val("timeout_set", CFG_W'(cfg_timeout), 48'd1);
        run_frame(1'b0, 8'd1);
        check_val("timeout_sticky", CFG_W'(cfg_timeout), 48'd1);
        check_val("overrun_hold", CFG_W'(overrun_cnt), 48'd1);

        // mid-frame reset returns to boot
        expect_ev(EV_SOF, 48'd2);
        tick(1'b0);
        wait_events("pre_reset_sof", 4);
        @(negedge clk);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("midreset");
        nrst = 1'b1;
        tick(1'b0);
        repeat (8) @(negedge clk);
        check_val("reset_boot_discard", CFG_W'(events_seen), CFG_W'(events_exp));
        end_cfg_pulse();
        run_frame(1'b0, 8'd1);

        check_val("queue_empty", CFG_W'(exp_q.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
